// File: rtl/debug_slave_sysclk_sampler.sv
// -----------------------------------------------------------------------------
// debug_slave_sysclk_sampler
//
// Oversamples the virtual-JTAG signals into the system clock domain. It
// implements a DR_W-bit capture/shift/update data register there. Each
// accepted update word is handed to the OCI logic as a one-hot
// take_action / take_no_action request over a valid/ready style handshake.
// An update that arrives while a request is still outstanding (and not being
// accepted in that same cycle) is dropped and flagged in a sticky overrun bit.
//
// clk must run at least 4x faster than tck. Every JTAG input is treated as
// asynchronous data.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   tck, tdi          JTAG clock and serial data in (asynchronous)
//   tdo               serial data out, LSB of the shift register
//   vs_cdr/sdr/udr/uir virtual capture-DR / shift-DR / update-DR / update-IR
//   ir_in             instruction from the JTAG hub (asynchronous)
//   cap_data          parallel capture word for the current instruction
//   cap_ir            latched instruction, selects cap_data upstream
//   jdo               last accepted update word
//   take_action       one-hot request, used when jdo[DR_W-1] = 1
//   take_no_action    one-hot request, used when jdo[DR_W-1] = 0
//   act_ready         consumer accepts the pending request
//   overrun           sticky flag: an update word was lost
//   clr_overrun       clears overrun (a simultaneous set wins)
// -----------------------------------------------------------------------------
module debug_slave_sysclk_sampler #(
  parameter int DR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2   // minimum 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tck,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [DR_W-1:0]        cap_data,
  output logic [IR_W-1:0]        cap_ir,
  output logic [DR_W-1:0]        jdo,
  output logic [(2**IR_W)-1:0]   take_action,
  output logic [(2**IR_W)-1:0]   take_no_action,
  input  logic                   act_ready,
  output logic                   overrun,
  input  logic                   clr_overrun
);

  localparam int NREQ        = 2 ** IR_W;
  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

  // Single-bit JTAG signals travel through the synchroniser as one bundle.
  typedef struct packed {
    logic uir;
    logic udr;
    logic sdr;
    logic cdr;
    logic tdi;
    logic tck;
  } jtag_bits_t;

  typedef enum logic {
    REQ_IDLE    = 1'b0,
    REQ_PENDING = 1'b1
  } req_state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  jtag_bits_t       jtag_raw;
  jtag_bits_t       sync_q    [SYNC_STAGES];
  logic [IR_W-1:0]  ir_sync_q [SYNC_STAGES];
  jtag_bits_t       jtag_s;
  logic [IR_W-1:0]  ir_s;

  always_comb begin
    jtag_raw     = '0;
    jtag_raw.uir = vs_uir;
    jtag_raw.udr = vs_udr;
    jtag_raw.sdr = vs_sdr;
    jtag_raw.cdr = vs_cdr;
    jtag_raw.tdi = tdi;
    jtag_raw.tck = tck;
  end

  // NOTE: synchroniser stages are ordinary flops, not a memory, so they are
  // reset like any other state; this keeps a freshly reset block from seeing
  // stale high levels as edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i]    <= '0;
        ir_sync_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0]    <= jtag_raw;
      ir_sync_q[0] <= ir_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i]    <= sync_q[i-1];
        ir_sync_q[i] <= ir_sync_q[i-1];
      end
    end
  end

  assign jtag_s = sync_q[SYNC_STAGES-1];
  assign ir_s   = ir_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge detection with post-reset warm-up
  // ---------------------------------------------------------------------------
  logic              tck_d;
  logic              udr_d;
  logic              uir_d;
  logic [WARM_W-1:0] warm_cnt;
  logic              edge_en;
  logic              tck_rise;
  logic              udr_rise;
  logic              uir_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      tck_d <= 1'b0;
      udr_d <= 1'b0;
      uir_d <= 1'b0;
    end else begin
      tck_d <= jtag_s.tck;
      udr_d <= jtag_s.udr;
      uir_d <= jtag_s.uir;
    end
  end

  // Edge detection stays off until the synchroniser and the delay flops hold
  // real samples. A level that was already high at reset then shows up in
  // both the synchronised and delayed copies and never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_W'(WARM_CYCLES)) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  assign edge_en  = (warm_cnt == WARM_W'(WARM_CYCLES));
  assign tck_rise = edge_en & jtag_s.tck & ~tck_d;
  assign udr_rise = edge_en & jtag_s.udr & ~udr_d;
  assign uir_rise = edge_en & jtag_s.uir & ~uir_d;

  // ---------------------------------------------------------------------------
  // Capture / shift data register and instruction latch
  // ---------------------------------------------------------------------------
  logic [DR_W-1:0] sr;

  // Capture takes priority when cdr and sdr are both seen on one tck edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (tck_rise) begin
      if (jtag_s.cdr) begin
        sr <= cap_data;
      end else if (jtag_s.sdr) begin
        sr <= {jtag_s.tdi, sr[DR_W-1:1]};
      end
    end
  end

  assign tdo = sr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_ir <= '0;
    end else if (uir_rise) begin
      cap_ir <= ir_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Request handshake
  // ---------------------------------------------------------------------------
  req_state_t      req_state;
  req_state_t      req_next;
  logic            load_dr;
  logic            overrun_set;
  logic            pending;
  logic [IR_W-1:0] ir_act;
  logic [NREQ-1:0] req_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_state <= REQ_IDLE;
    end else begin
      req_state <= req_next;
    end
  end

  // A new update is taken when nothing is outstanding, or when the outstanding
  // request is being accepted in the very same cycle (back-to-back handoff).
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    req_next    = req_state;
    load_dr     = 1'b0;
    overrun_set = 1'b0;
    case (req_state)
      REQ_IDLE: begin
        if (udr_rise) begin
          load_dr  = 1'b1;
          req_next = REQ_PENDING;
        end
      end
      REQ_PENDING: begin
        if (udr_rise) begin
          if (act_ready) begin
            load_dr = 1'b1;
          end else begin
            overrun_set = 1'b1;
          end
        end else if (act_ready) begin
          req_next = REQ_IDLE;
        end
      end
      default: req_next = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jdo    <= '0;
      ir_act <= '0;
    end else if (load_dr) begin
      jdo    <= sr;
      ir_act <= cap_ir;
    end
  end

  // A set in the same cycle as a clear wins so that a lost word is never
  // silently forgotten.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign pending = (req_state == REQ_PENDING);

  always_comb begin
    req_onehot         = '0;
    req_onehot[ir_act] = 1'b1;
  end

  assign take_action    = (pending &&  jdo[DR_W-1]) ? req_onehot : '0;
  assign take_no_action = (pending && !jdo[DR_W-1]) ? req_onehot : '0;

endmodule

// File: tb/tb_debug_slave_sysclk_sampler.sv
module tb_debug_slave_sysclk_sampler;

  localparam int DR_W        = 38;
  localparam int IR_W        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int NREQ        = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            tck;
  logic            tdi;
  logic            tdo;
  logic            vs_cdr;
  logic            vs_sdr;
  logic            vs_udr;
  logic            vs_uir;
  logic [IR_W-1:0] ir_in;
  logic [DR_W-1:0] cap_data;
  logic [IR_W-1:0] cap_ir;
  logic [DR_W-1:0] jdo;
  logic [NREQ-1:0] take_action;
  logic [NREQ-1:0] take_no_action;
  logic            act_ready;
  logic            overrun;
  logic            clr_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  debug_slave_sysclk_sampler #(
    .DR_W        (DR_W),
    .IR_W        (IR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tck            (tck),
    .tdi            (tdi),
    .tdo            (tdo),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .cap_data       (cap_data),
    .cap_ir         (cap_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .act_ready      (act_ready),
    .overrun        (overrun),
    .clr_overrun    (clr_overrun)
  );

  always #5 clk = ~clk;

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] cap;
    logic [DR_W-1:0] word;
    logic [NREQ-1:0] exp_ta;
    logic [NREQ-1:0] exp_tna;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ir_update(input logic [IR_W-1:0] ir);
    ir_in = ir;
    step(2);
    vs_uir = 1'b1;
    step(4);
    vs_uir = 1'b0;
    step(4);
  endtask

  // One capture pulse (optionally with vs_sdr also high), then n_bits shifts
  // of word LSB first. tdo is sampled before each shift.
  task automatic shift_word(input logic [DR_W-1:0] cap, input logic [DR_W-1:0] word,
                            input logic both, input int n_bits,
                            output logic [DR_W-1:0] tdo_word);
    tdo_word = '0;
    cap_data = cap;
    vs_cdr   = 1'b1;
    vs_sdr   = both;
    tdi      = 1'b1;
    step(1);
    tck = 1'b1;
    step(4);
    tck = 1'b0;
    step(3);
    vs_cdr = 1'b0;
    for (int i = 0; i < n_bits; i++) begin
      tdo_word[i] = tdo;
      vs_sdr = 1'b1;
      tdi    = word[i];
      step(1);
      tck = 1'b1;
      step(4);
      tck = 1'b0;
      step(3);
    end
    vs_sdr = 1'b0;
  endtask

  // vs_udr high for four cycles; act_ready / clr_overrun optionally driven
  // in the single cycle where the synchronised update edge is seen.
  task automatic dr_update(input logic ack_same, input logic clr_same);
    vs_udr = 1'b1;
    step(2);
    act_ready   = ack_same;
    clr_overrun = clr_same;
    step(1);
    act_ready   = 1'b0;
    clr_overrun = 1'b0;
    step(1);
    vs_udr = 1'b0;
    step(3);
  endtask

  task automatic ack();
    act_ready = 1'b1;
    step(1);
    act_ready = 1'b0;
  endtask

  logic [DR_W-1:0] tdo_word;
  logic [DR_W-1:0] word_a;
  logic [DR_W-1:0] word_b;
  logic [DR_W-1:0] cap_c;

  initial begin
    vecs[0] = '{ir: 2'd2, cap: 38'h15_5555_5555, word: 38'h2A_AAAA_AAAA, exp_ta: 4'b0100, exp_tna: 4'b0000};
    vecs[1] = '{ir: 2'd1, cap: 38'h00_1234_5678, word: 38'h0F_0F0F_0F0F, exp_ta: 4'b0000, exp_tna: 4'b0010};
    vecs[2] = '{ir: 2'd3, cap: 38'h3F_FFFF_FFFF, word: 38'h20_0000_0001, exp_ta: 4'b1000, exp_tna: 4'b0000};
    vecs[3] = '{ir: 2'd0, cap: 38'h00_0000_0000, word: 38'h1F_FFFF_FFFF, exp_ta: 4'b0000, exp_tna: 4'b0001};
    word_a = 38'h2A_AAAA_AAAA;
    word_b = 38'h11_2233_4455;
    cap_c  = 38'h15_5555_5555;

    // Reset with tck, vs_udr, vs_uir, vs_sdr and tdi already high.
    reset       = 1'b1;
    tck         = 1'b1;
    tdi         = 1'b1;
    vs_cdr      = 1'b0;
    vs_sdr      = 1'b1;
    vs_udr      = 1'b1;
    vs_uir      = 1'b1;
    ir_in       = 2'd3;
    cap_data    = '0;
    act_ready   = 1'b0;
    clr_overrun = 1'b0;
    step(3);
    check("reset_jdo", 64'(jdo), 64'h0);
    check("reset_cap_ir", 64'(cap_ir), 64'h0);
    check("reset_tdo", 64'(tdo), 64'h0);
    check("reset_overrun", 64'(overrun), 64'h0);
    check("reset_req", 64'({take_action, take_no_action}), 64'h0);

    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("warmup_req", 64'({take_action, take_no_action}), 64'h0);
    end
    check("warmup_jdo", 64'(jdo), 64'h0);
    check("warmup_cap_ir", 64'(cap_ir), 64'h0);
    check("warmup_tdo", 64'(tdo), 64'h0);
    tck    = 1'b0;
    tdi    = 1'b0;
    vs_sdr = 1'b0;
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    step(4);

    // Table-driven full transactions.
    for (int v = 0; v < 4; v++) begin
      ir_update(vecs[v].ir);
      check("vec_cap_ir", 64'(cap_ir), 64'(vecs[v].ir));
      shift_word(vecs[v].cap, vecs[v].word, 1'b0, DR_W, tdo_word);
      check("vec_tdo_stream", 64'(tdo_word), 64'(vecs[v].cap));
      dr_update(1'b0, 1'b0);
      check("vec_jdo", 64'(jdo), 64'(vecs[v].word));
      check("vec_take_action", 64'(take_action), 64'(vecs[v].exp_ta));
      check("vec_take_no_action", 64'(take_no_action), 64'(vecs[v].exp_tna));
      check("vec_no_overrun", 64'(overrun), 64'h0);
      step(5);
      check("vec_req_held", 64'({take_action, take_no_action}),
            64'({vecs[v].exp_ta, vecs[v].exp_tna}));
      ack();
      check("vec_req_dropped", 64'({take_action, take_no_action}), 64'h0);
    end

    // Ignored act_ready while idle.
    ack();
    check("idle_ack_ignored", 64'({take_action, take_no_action}), 64'h0);

    // Overrun: second update while pending, clear asserted in the same cycle.
    ir_update(2'd2);
    shift_word(cap_c, word_a, 1'b0, DR_W, tdo_word);
    dr_update(1'b0, 1'b0);
    check("ovr_first_jdo", 64'(jdo), 64'(word_a));
    shift_word(cap_c, word_b, 1'b0, DR_W, tdo_word);
    dr_update(1'b0, 1'b1);
    check("ovr_jdo_held", 64'(jdo), 64'(word_a));
    check("ovr_set_beats_clr", 64'(overrun), 64'h1);
    check("ovr_req_kept", 64'(take_action), 64'h4);
    ir_update(2'd1);
    check("ir_update_keeps_req", 64'({take_action, take_no_action}), 64'h40);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    check("ovr_cleared", 64'(overrun), 64'h0);

    // Update in the same cycle as act_ready: back-to-back handoff.
    shift_word(cap_c, word_b, 1'b0, DR_W, tdo_word);
    dr_update(1'b1, 1'b0);
    check("handoff_jdo", 64'(jdo), 64'(word_b));
    check("handoff_take_no_action", 64'(take_no_action), 64'h2);
    check("handoff_take_action", 64'(take_action), 64'h0);
    check("handoff_no_overrun", 64'(overrun), 64'h0);
    ack();
    check("handoff_dropped", 64'({take_action, take_no_action}), 64'h0);

    // Capture wins over shift on the same tck edge.
    shift_word(cap_c, {DR_W{1'b1}}, 1'b1, DR_W, tdo_word);
    check("cdr_sdr_capture_wins", 64'(tdo_word), 64'(cap_c));

    // Reset in the middle of shifting bit 17.
    shift_word(cap_c, word_a, 1'b0, 17, tdo_word);
    vs_sdr = 1'b1;
    tdi    = 1'b0;
    step(1);
    tck = 1'b1;
    step(2);
    reset = 1'b1;
    step(2);
    check("midreset_tdo", 64'(tdo), 64'h0);
    check("midreset_cap_ir", 64'(cap_ir), 64'h0);
    reset = 1'b0;
    step(3);
    tck    = 1'b0;
    vs_sdr = 1'b0;
    step(6);
    check("midreset_no_req", 64'({take_action, take_no_action}), 64'h0);
    dr_update(1'b0, 1'b0);
    check("midreset_jdo_zero", 64'(jdo), 64'h0);
    check("midreset_take_no_action", 64'(take_no_action), 64'h1);
    ack();
    check("midreset_dropped", 64'({take_action, take_no_action}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_slave_sysclk_sampler.md
Name: debug_slave_sysclk_sampler

Overview:
- Parametrised successor of the CPU debug-slave TCK/sysclk pair.
- Oversamples the virtual-JTAG signals into the system clock domain and implements a DR_W-bit capture/shift/update data register there.
- Latches an IR_W-bit instruction and issues one-hot take_action / take_no_action requests to the OCI logic over a valid/ready handshake, with overrun detection.
- Sits between the sld_virtual_jtag_basic instance and the debug module; one clock domain only.

Parameters:
- DR_W, 38, data register width; jdo width; DR_W-1 is the action bit.
- IR_W, 2, instruction width; 2**IR_W one-hot request lines.
- SYNC_STAGES, 2, synchroniser depth for tck/tdi/vs_*/ir_in (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x the tck frequency.
- reset  in  1  synchronous, active-high reset.
- tck  in  1  JTAG clock, asynchronous, sampled as data.
- tdi  in  1  serial data in, asynchronous.
- tdo  out  1  serial data out (sr[0]).
- vs_cdr  in  1  virtual capture-DR state.
- vs_sdr  in  1  virtual shift-DR state.
- vs_udr  in  1  virtual update-DR state.
- vs_uir  in  1  virtual update-IR state.
- ir_in  in  IR_W  instruction from the JTAG hub.
- cap_data  in  DR_W  parallel capture word for the current instruction.
- cap_ir  out  IR_W  latched instruction; selects cap_data upstream.
- jdo  out  DR_W  last accepted update word.
- take_action  out  2**IR_W  one-hot request; the bit for ir_act is set when jdo[DR_W-1]=1.
- take_no_action  out  2**IR_W  one-hot request; the bit for ir_act is set when jdo[DR_W-1]=0.
- act_ready  in  1  consumer accepts the pending request.
- overrun  out  1  sticky: an update was lost.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset: sr, jdo, cap_ir, ir_act, pending, overrun = 0. take_action and take_no_action = 0. tdo = 0. All synchroniser flops = 0.
- Warm-up: a counter suppresses all edge detection for SYNC_STAGES+1 cycles after reset is released. Synchroniser and delayed copies run during warm-up, so signals already high at reset produce no edge.
- Synchronisation: tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir and ir_in each pass through SYNC_STAGES flops, plus one delay flop per signal for edge detection.
- tck_rise = tck_s & ~tck_d. Action occurs SYNC_STAGES+1 clk cycles after the external tck edge.
- Capture: on tck_rise with vs_cdr_s=1, sr <= cap_data.
- Shift: on tck_rise with vs_sdr_s=1, sr <= {tdi_s, sr[DR_W-1:1]}. LSB first out, MSB first in.
- cdr and sdr both high on the same tck_rise: capture wins.
- tdo = sr[0], combinational from the register.
- IR update: on the rising edge of vs_uir_s, cap_ir <= ir_in_s. An IR update does not disturb sr or pending.
- DR update: on the rising edge of vs_udr_s (udr_rise):
  - If pending=0, or pending=1 and act_ready=1 in the same cycle: jdo <= sr, ir_act <= cap_ir, pending <= 1.
  - Otherwise: jdo and ir_act are held and overrun <= 1.
- Handshake:
  - Outputs are asserted while pending=1: take_action = jdo[DR_W-1] ? onehot(ir_act) : 0, and take_no_action = jdo[DR_W-1] ? 0 : onehot(ir_act).
  - act_ready with pending=1 and no udr_rise: pending <= 0, and all request outputs drop on the next cycle.
  - act_ready while pending=0 is ignored.
- Exactly one request bit is high whenever pending=1; none are high otherwise.
- overrun: set and clr_overrun in the same cycle leaves it set. Otherwise clr_overrun clears it.
- Reset mid-shift or mid-request returns to the reset state; the partial word is discarded and warm-up re-applies.
- Edge cases:
  - A vs_udr held high produces one update only.
  - A tck glitch shorter than one clk period may be missed; this is outside the supported envelope.

Test Plan:
1. Reset release with tck=1, vs_udr=1 held -> no shift, pending stays 0, take_* = 0 for 10 cycles.
2. DR_W=38, IR_W=2: shift ir=2 via uir, then cdr with cap_data=0x15_5555_5555, then 38 tck pulses on tdi = 0x2A_AAAA_AAAA -> tdo streams cap_data LSB first; after udr, jdo=0x2A_AAAA_AAAA, take_action=4'b0100, act_ready pulse -> take_action=0 next cycle.
3. Word with bit37=0, ir=1 -> take_no_action=4'b0010, take_action=0, held until act_ready.
4. Second udr while pending and act_ready=0 -> jdo unchanged, overrun=1; clr_overrun with no new set -> overrun=0.
5. udr_rise in the same cycle as act_ready -> new jdo loaded, pending stays 1, overrun=0.
6. cdr and sdr asserted on the same tck edge -> sr=cap_data (no shift); reset asserted mid-shift at bit 17 -> sr=0, tdo=0.
